// File: rtl/high_speed_bus_interface.sv
// SECDED (39,32) link stage: encode into a codeword register, decode next cycle.
// Ports: clk, rst (sync, active-high), valid_in/data_in in; valid_out/data_out/error_detected/error_corrected out.
module high_speed_bus_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic        error_detected,
    output logic        error_corrected
);

    logic [38:0] cw_q;
    logic        cw_vld_q;

    logic [5:0]  syn;
    logic        par;
    logic [38:0] fix;
    logic [31:0] dec_data;
    logic        dec_det;
    logic        dec_cor;

    // Positions 1,2,4,8,16,32 carry check bits; 0 is the overall parity bit.
    function automatic logic is_check_pos(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if (!is_check_pos(p)) begin
                c[6'(p)] = d[5'(j)];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            for (int p = 1; p < 39; p++) begin
                if (!is_check_pos(p) && (((p >> k) & 1) == 1))
                    c[6'(1 << k)] = c[6'(1 << k)] ^ c[6'(p)];
            end
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] c);
        logic [31:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if (!is_check_pos(p)) begin
                d[5'(j)] = c[6'(p)];
                j++;
            end
        end
        return d;
    endfunction

    always_comb begin
        syn = '0;
        for (int p = 1; p < 39; p++) begin
            if (cw_q[6'(p)])
                syn = syn ^ 6'(p);
        end
        par = ^cw_q;
        // Flip only for a single error inside 1..38; every other case
        // leaves the word untouched so the raw data comes out.
        fix = cw_q;
        for (int p = 1; p < 39; p++) begin
            if (par && (syn == 6'(p)))
                fix[6'(p)] = ~fix[6'(p)];
        end
        dec_data = extract(fix);
        dec_det  = (syn != 6'd0) || par;
        dec_cor  = par && (syn <= 6'd38);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_q            <= '0;
            cw_vld_q        <= 1'b0;
            valid_out       <= 1'b0;
            data_out        <= '0;
            error_detected  <= 1'b0;
            error_corrected <= 1'b0;
        end else begin
            if (valid_in) begin
                cw_q     <= encode(data_in);
                cw_vld_q <= 1'b1;
            end else begin
                cw_vld_q <= 1'b0;
            end
            if (cw_vld_q) begin
                valid_out       <= 1'b1;
                data_out        <= dec_data;
                error_detected  <= dec_det;
                error_corrected <= dec_cor;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_high_speed_bus_interface.sv
// Self-checking bench for high_speed_bus_interface.
// Random traffic and bit-flip injection against a flip-count reference model.
module tb_high_speed_bus_interface;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        error_detected;
    logic        error_corrected;

    int n_tests;
    int n_fail;

    logic        hv[$];
    logic [31:0] hd[$];
    logic [38:0] inj;

    high_speed_bus_interface dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .error_detected  (error_detected),
        .error_corrected (error_corrected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Data bit index held at codeword position p, or -1 for parity/check slots.
    function automatic int data_idx(input int p);
        int n;
        if (p == 0 || p == 1 || p == 2 || p == 4 || p == 8 ||
            p == 16 || p == 32)
            return -1;
        n = 0;
        for (int q = 3; q < p; q++)
            if (q != 4 && q != 8 && q != 16 && q != 32)
                n++;
        return n;
    endfunction

    // Reference: outcome depends only on how many bits were flipped.
    task automatic model(input logic [31:0] d, input logic [38:0] mask,
                         output logic [31:0] ed, output logic edet,
                         output logic ecor);
        int n;
        n  = $countones(mask);
        ed = d;
        if (n == 0) begin
            edet = 1'b0;
            ecor = 1'b0;
        end else if (n == 1) begin
            edet = 1'b1;
            ecor = 1'b1;
        end else begin
            edet = 1'b1;
            ecor = 1'b0;
            for (int p = 0; p < 39; p++)
                if (mask[p] && data_idx(p) >= 0)
                    ed[data_idx(p)] = ~ed[data_idx(p)];
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] d,
                           input logic [38:0] mask);
        logic [31:0] ed;
        logic        edet;
        logic        ecor;
        model(d, mask, ed, edet, ecor);
        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = $urandom;
        if (mask != '0) begin
            inj = dut.cw_q ^ mask;
            force dut.cw_q = inj;
        end
        @(posedge clk); #1;
        if (mask != '0)
            release dut.cw_q;
        chk({tag, "_vld"}, 32'(valid_out), 32'd1);
        chk({tag, "_data"}, data_out, ed);
        chk({tag, "_det"}, 32'(error_detected), 32'(edet));
        chk({tag, "_cor"}, 32'(error_corrected), 32'(ecor));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(valid_out), 32'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        logic        ev;
        logic [31:0] ed;
        @(posedge clk); #1;
        if (hv.size() == 2) begin
            ev = hv.pop_front();
            ed = hd.pop_front();
            chk("b2b_vld", 32'(valid_out), 32'(ev));
            if (ev) begin
                chk("b2b_data", data_out, ed);
                chk("b2b_flags", {30'd0, error_detected, error_corrected}, 32'd0);
            end
        end
        valid_in = v;
        data_in  = d;
        hv.push_back(v);
        hd.push_back(d);
    endtask

    initial begin
        logic [38:0] m;
        int          p1;
        int          p2;
        int          nf;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vld", 32'(valid_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_det", 32'(error_detected), 32'd0);
        chk("rst_cor", 32'(error_corrected), 32'd0);

        run_one("clean", 32'hA5A5A5A5, 39'd0);
        run_one("d5flip", 32'hFFFFFFFF, 39'd1 << 10);
        run_one("p0flip", 32'h12345678, 39'd1);
        run_one("c32flip", 32'h12345678, 39'd1 << 32);
        run_one("dbl", 32'h98765432, (39'd1 << 5) | (39'd1 << 14));

        for (int i = 0; i < 300; i++) begin
            nf = int'($urandom_range(0, 2));
            p1 = int'($urandom_range(0, 38));
            do p2 = int'($urandom_range(0, 38)); while (p2 == p1);
            m = '0;
            if (nf >= 1) m[p1] = 1'b1;
            if (nf == 2) m[p2] = 1'b1;
            run_one("rnd_inj", $urandom, m);
        end

        repeat (3) step(1'b0, 32'd0);
        for (int i = 0; i < 1000; i++)
            step(1'b1, $urandom);
        repeat (2) step(1'b0, 32'd0);

        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in  = 32'hCAFEF00D;
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_vld", 32'(valid_out), 32'd0);
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_flags", {30'd0, error_detected, error_corrected}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_vld2", 32'(valid_out), 32'd0);
        chk("midrst_data2", data_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
